// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers.
// One-shot and auto-reload modes, registered interrupt request.
module timer_counter #(
   parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CNT,
      S_INT
   } state_t;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;

   state_t      state;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;

   logic en;
   logic im;
   logic mode_auto;
   logic ctrl_wr;
   logic preset_wr;
   logic count_zero;

   assign en         = ctrl[0];
   assign im         = ctrl[3];
   assign mode_auto  = (ctrl[2:1] == 2'b01);
   assign ctrl_wr    = we && (addr == A_CTRL);
   assign preset_wr  = we && (addr == A_PRESET);
   assign count_zero = (count == 32'd0);

   // FSM, counter and register file; a CTRL write overrides
   // the FSM's own EN clear and irq update on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         ctrl   <= 4'b0000;
         preset <= RESET_PRESET;
         count  <= 32'd0;
         irq    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (en)
                  state <= S_LOAD;
            end
            S_LOAD: begin
               count <= preset;
               state <= S_CNT;
            end
            S_CNT: begin
               if (!en) begin
                  state <= S_IDLE;
               end else if (count_zero) begin
                  state <= S_INT;
                  if (im)
                     irq <= 1'b1;
               end else begin
                  count <= count - 32'd1;
               end
            end
            S_INT: begin
               if (mode_auto) begin
                  state <= S_LOAD;
                  irq   <= 1'b0;
               end else begin
                  ctrl[0] <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (ctrl_wr) begin
            ctrl <= wdata[3:0];
            irq  <= 1'b0;
         end

         if (preset_wr)
            preset <= wdata;
      end
   end

   // Read mux reflects current (pre-edge) register contents.
   always_comb begin
      rdata = 32'd0;
      case (addr)
         A_CTRL:   rdata = {28'd0, ctrl};
         A_PRESET: rdata = preset;
         A_COUNT:  rdata = count;
         default:  rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed timing
// scenarios plus randomized traffic against a reference model.
module tb_timer_counter;

   localparam logic [31:0] RP = 32'h0000_0007;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [3:0]  m_ctrl;
   logic [31:0] m_pre;
   logic [31:0] m_cnt;
   logic        m_irq;
   int          m_ph;

   always #5 clk = ~clk;

   timer_counter #(.RESET_PRESET(RP)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   // phases: 0 idle, 1 load, 2 counting, 3 expired
   task automatic model_edge();
      logic [3:0]  c;
      logic [31:0] p;
      logic [31:0] n;
      logic        q;
      int          ph;
      c = m_ctrl; p = m_pre; n = m_cnt; q = m_irq; ph = m_ph;
      if (reset) begin
         c = 4'd0; p = RP; n = 0; q = 0; ph = 0;
      end else begin
         if (m_ph == 0) begin
            if (m_ctrl[0]) ph = 1;
         end else if (m_ph == 1) begin
            n = m_pre; ph = 2;
         end else if (m_ph == 2) begin
            if (!m_ctrl[0]) ph = 0;
            else if (m_cnt == 0) begin
               ph = 3;
               if (m_ctrl[3]) q = 1;
            end else n = m_cnt - 1;
         end else begin
            if (m_ctrl[2:1] == 2'b01) begin
               ph = 1; q = 0;
            end else begin
               c[0] = 1'b0; ph = 0;
            end
         end
         if (we && addr == 2'd0) begin
            c = wdata[3:0]; q = 0;
         end
         if (we && addr == 2'd1) p = wdata;
      end
      m_ctrl = c; m_pre = p; m_cnt = n; m_irq = q; m_ph = ph;
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return {28'd0, m_ctrl};
         2'd1: return m_pre;
         2'd2: return m_cnt;
         default: return 32'd0;
      endcase
   endfunction

   task automatic clk_edge();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      clk_edge();
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = rdata;
   endtask

   task automatic do_reset();
      reset = 1'b1; we = 1'b0;
      clk_edge();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic [31:0] exp_v [4];
      exp_v[0] = 0; exp_v[1] = RP; exp_v[2] = 0; exp_v[3] = 0;
      do_reset();
      for (int a = 0; a < 4; a++) begin
         rd(a[1:0], v);
         checks++;
         if (v !== exp_v[a]) begin
            errors++;
            $display("FAIL reset_rd%0d got %h exp %h", a, v, exp_v[a]);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq got %b exp 0", irq);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      clk_edge();
      for (int k = 2; k <= 5; k++) begin
         clk_edge();
         rd(2'd2, v);
         checks++;
         if (v !== 32'(5 - k) || irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_cnt E%0d got %0d/%b exp %0d/0",
                     k, v, irq, 5 - k);
         end
      end
      clk_edge();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_irq got %b exp 1", irq);
      end
      repeat (4) clk_edge();
      rd(2'd0, v);
      checks++;
      if (v !== 32'h8 || irq !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_hold got %h/%b exp 8/1", v, irq);
      end
      wr(2'd0, 32'h8);
      repeat (3) clk_edge();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_clr got %b exp 0", irq);
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] v;
      logic [31:0] ec;
      logic        ei;
      int          p;
      do_reset();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 27; k++) begin
         clk_edge();
         ei = (k >= 5) && (k % 5 == 0);
         checks++;
         if (irq !== ei) begin
            errors++;
            $display("FAIL auto_irq E%0d got %b exp %b", k, irq, ei);
         end
         if (k >= 2) begin
            p = (k - 2) % 5;
            ec = (p == 0) ? 32'd2 : (p == 1) ? 32'd1 : 32'd0;
            rd(2'd2, v);
            checks++;
            if (v !== ec) begin
               errors++;
               $display("FAIL auto_cnt E%0d got %0d exp %0d", k, v, ec);
            end
         end
      end
      wr(2'd0, 32'h0);
      repeat (6) clk_edge();
   endtask

   task automatic test_abort();
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      repeat (3) clk_edge();
      wr(2'd1, 32'd99);
      rd(2'd2, v);
      checks++;
      if (v !== 32'd8) begin
         errors++;
         $display("FAIL abort_prewr got %0d exp 8", v);
      end
      clk_edge();
      wr(2'd0, 32'h0);
      clk_edge();
      repeat (3) clk_edge();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd6 || irq !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold got %0d/%b exp 6/0", v, irq);
      end
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      clk_edge();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd6) begin
         errors++;
         $display("FAIL abort_load got %0d exp 6", v);
      end
      clk_edge();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd10) begin
         errors++;
         $display("FAIL abort_reload got %0d exp 10", v);
      end
   endtask

   task automatic test_mask();
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);
      repeat (3) clk_edge();
      rd(2'd0, v);
      checks++;
      if (v !== 32'h1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL mask_int got %h/%b exp 1/0", v, irq);
      end
      clk_edge();
      rd(2'd0, v);
      checks++;
      if (v !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL mask_en got %h/%b exp 0/0", v, irq);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd20);
      wr(2'd0, 32'h9);
      repeat (17) clk_edge();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd5) begin
         errors++;
         $display("FAIL rmid_pre got %0d exp 5", v);
      end
      reset = 1'b1;
      clk_edge();
      reset = 1'b0;
      rd(2'd1, v);
      checks++;
      if (v !== RP) begin
         errors++;
         $display("FAIL rmid_preset got %h exp %h", v, RP);
      end
      repeat (5) clk_edge();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL rmid_idle got %0d/%b exp 0/0", v, irq);
      end
   endtask

   task automatic test_collision();
      logic [31:0] v;
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      repeat (4) clk_edge();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL coll_int got %b exp 1", irq);
      end
      wr(2'd0, 32'h9);
      rd(2'd0, v);
      checks++;
      if (v !== 32'h9 || irq !== 1'b0) begin
         errors++;
         $display("FAIL coll_ctrl got %h/%b exp 9/0", v, irq);
      end
      clk_edge();
      clk_edge();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd1) begin
         errors++;
         $display("FAIL coll_reload got %0d exp 1", v);
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [1:0]  a;
      do_reset();
      repeat (800) begin
         a = 2'($urandom_range(0, 3));
         rd(a, v);
         checks++;
         if (v !== m_read(a) || irq !== m_irq) begin
            errors++;
            $display("FAIL rand_rd%0d got %h/%b exp %h/%b",
                     a, v, irq, m_read(a), m_irq);
         end
         reset = ($urandom_range(0, 149) == 0);
         we    = ($urandom_range(0, 5) == 0);
         addr  = 2'($urandom_range(0, 3));
         if (addr == 2'd1) wdata = $urandom_range(0, 6);
         else              wdata = $urandom;
         clk_edge();
         reset = 1'b0;
         we    = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = 32'd0;
      test_reset();
      test_oneshot();
      test_autoreload();
      test_abort();
      test_mask();
      test_reset_mid();
      test_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
